// File: rtl/grant_lock.sv
// Ownership lock behind the 4-way fixed-priority arbiter: latches one winner,
// holds it until release or timeout, then inserts a one-cycle turnaround.
module grant_lock #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] grant,
    input  logic [1:0] grant_num,
    input  logic       available,
    input  logic [3:0] release_req,
    output logic [3:0] owner,
    output logic [1:0] owner_num,
    output logic       busy,
    output logic       timeout_err,
    output logic       proto_err
);

    localparam int            CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWNED    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] num;
        logic       avail;
    } arb_t;

    state_t        state;
    logic [CW-1:0] cnt;
    arb_t          arb;
    logic          arb_legal;
    logic          arb_quiet;
    logic          owner_rel;

    assign arb       = '{grant: grant, num: grant_num, avail: available};
    // One-hot plus matching index collapses to a single decode compare.
    assign arb_legal = !arb.avail && (arb.grant == (4'b0001 << arb.num));
    assign arb_quiet = arb.avail && (arb.grant == 4'b0000);
    assign owner_rel = release_req[owner_num];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            owner       <= 4'b0000;
            owner_num   <= 2'd0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_legal) begin
                        owner     <= arb.grant;
                        owner_num <= arb.num;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        state     <= OWNED;
                    end else if (!arb_quiet) begin
                        proto_err <= 1'b1;
                    end
                end
                OWNED: begin
                    // Release beats a same-cycle timeout.
                    if (owner_rel || (cnt == CNT_MAX)) begin
                        timeout_err <= !owner_rel;
                        owner       <= 4'b0000;
                        owner_num   <= 2'd0;
                        busy        <= 1'b0;
                        cnt         <= '0;
                        state       <= COOLDOWN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COOLDOWN: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    owner     <= 4'b0000;
                    owner_num <= 2'd0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grant_lock.sv
// Bench for grant_lock: edge-count reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_grant_lock;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] grant;
    logic [1:0] grant_num;
    logic       available;
    logic [3:0] release_req;
    logic [3:0] owner;
    logic [1:0] owner_num;
    logic       busy;
    logic       timeout_err;
    logic       proto_err;

    int nchecks = 0;
    int nerr    = 0;

    grant_lock #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .grant      (grant),
        .grant_num  (grant_num),
        .available  (available),
        .release_req(release_req),
        .owner      (owner),
        .owner_num  (owner_num),
        .busy       (busy),
        .timeout_err(timeout_err),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns, how many cycles it has been busy, and the
    // edge index from which the arbiter is looked at again.
    int         m_owner;
    int         m_age;
    longint     edge_n;
    longint     resume;
    logic [3:0] e_owner;
    logic [1:0] e_num;
    logic       e_busy, e_to, e_pe;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_age = 0; edge_n = 0; resume = 0;
            e_owner = 4'b0; e_num = 2'd0; e_busy = 1'b0; e_to = 1'b0; e_pe = 1'b0;
        end else begin
            e_to = 1'b0;
            e_pe = 1'b0;
            if (m_owner >= 0) begin
                if (release_req[m_owner]) begin
                    m_owner = -1; resume = edge_n + 2;
                end else if (m_age == TO) begin
                    m_owner = -1; resume = edge_n + 2; e_to = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (edge_n >= resume) begin
                if (!available && $countones(grant) == 1 && grant[grant_num]) begin
                    m_owner = int'(grant_num); m_age = 1;
                end else if (!(available && grant == 4'b0)) begin
                    e_pe = 1'b1;
                end
            end
            edge_n++;
            e_busy  = (m_owner >= 0);
            e_owner = e_busy ? (4'b0001 << m_owner) : 4'b0;
            e_num   = e_busy ? 2'(m_owner) : 2'd0;
        end
    end

    always @(negedge clk) begin
        check("outputs_vs_model", {owner, owner_num, busy, timeout_err, proto_err},
              {e_owner, e_num, e_busy, e_to, e_pe});
        check("err_exclusive", {31'b0, timeout_err & proto_err}, 32'd0);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_quiet();
        available = 1'b1; grant = 4'b0; grant_num = 2'd0; release_req = 4'b0;
    endtask

    task automatic go_idle();
        available = 1'b1; grant = 4'b0; grant_num = 2'd0; release_req = 4'hF;
        cyc(3);
        release_req = 4'b0;
    endtask

    task automatic own(input logic [3:0] g, input logic [1:0] gn);
        grant = g; grant_num = gn; available = 1'b0;
        cyc(1);
        set_quiet();
    endtask

    task automatic proto_case(input string nm, input logic [3:0] g, input logic [1:0] gn, input logic av);
        grant = g; grant_num = gn; available = av;
        cyc(1);
        set_quiet();
        check({nm, "_pulse"}, {31'b0, proto_err}, 32'd1);
        check({nm, "_busy"}, {31'b0, busy}, 32'd0);
        cyc(1);
        check({nm, "_clear"}, {31'b0, proto_err}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_quiet();
        cyc(2);
        check("reset_owner", {28'b0, owner}, 32'd0);
        check("reset_flags", {27'b0, owner_num, busy, timeout_err, proto_err}, 32'd0);
        rst_n = 1'b1;
        cyc(1);

        // Reset mid-ownership, then an immediate grant after reset release.
        own(4'b0100, 2'd2);
        check("t1_busy", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_owner", {28'b0, owner}, 32'd0);
        check("t1_async_busy", {31'b0, busy}, 32'd0);
        cyc(1);
        rst_n = 1'b1;
        own(4'b0001, 2'd0);
        check("t1_regrant", {27'b0, owner, busy}, {27'b0, 4'b0001, 1'b1});
        go_idle();

        // Basic ownership, release, turnaround with grant held.
        grant = 4'b1000; grant_num = 2'd3; available = 1'b0;
        cyc(1);
        check("t2_owner", {25'b0, owner, owner_num, busy}, {25'b0, 4'b1000, 2'd3, 1'b1});
        cyc(4);
        grant = 4'b0010; grant_num = 2'd1; release_req = 4'b1000;
        cyc(1);
        release_req = 4'b0;
        check("t2_released", {31'b0, busy}, 32'd0);
        cyc(1);
        check("t2_not_early", {28'b0, owner}, 32'd0);
        cyc(1);
        check("t2_new_owner", {28'b0, owner}, {28'b0, 4'b0010});
        go_idle();

        // Timeout.
        own(4'b0010, 2'd1);
        check("t3_busy_c1", {31'b0, busy}, 32'd1);
        cyc(15);
        check("t3_busy_c16", {30'b0, busy, timeout_err}, {30'b0, 2'b10});
        cyc(1);
        check("t3_timeout", {26'b0, owner, busy, timeout_err}, {26'b0, 4'b0, 1'b0, 1'b1});
        cyc(1);
        check("t3_to_clear", {31'b0, timeout_err}, 32'd0);
        go_idle();

        // Foreign release ignored; owner release at the last cycle wins.
        own(4'b0100, 2'd2);
        cyc(2);
        release_req = 4'b0001;
        cyc(1);
        release_req = 4'b0;
        check("t4_foreign", {31'b0, busy}, 32'd1);
        cyc(12);
        release_req = 4'b0100;
        cyc(1);
        release_req = 4'b0;
        check("t4_collide", {30'b0, busy, timeout_err}, 32'd0);
        cyc(1);
        check("t4_no_to", {31'b0, timeout_err}, 32'd0);
        go_idle();

        // Protocol errors in IDLE.
        proto_case("t5_not_onehot", 4'b0110, 2'd1, 1'b0);
        proto_case("t5_num_mismatch", 4'b0100, 2'd1, 1'b0);
        proto_case("t5_avail_grant", 4'b0001, 2'd0, 1'b1);
        proto_case("t5_no_grant", 4'b0000, 2'd0, 1'b0);

        // Arbiter inputs masked while owned.
        own(4'b0001, 2'd0);
        for (int i = 0; i < 6; i++) begin
            grant = 4'b1111; grant_num = 2'(i); available = i[0];
            cyc(1);
            check("t6_mask", {26'b0, owner, proto_err, busy}, {26'b0, 4'b0001, 1'b0, 1'b1});
        end
        release_req = 4'b0001;
        cyc(1);
        check("t6_release", {27'b0, owner, busy}, 32'd0);
        go_idle();

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            grant_num = 2'($urandom_range(0, 3));
            if (r < 60) begin
                grant = 4'b0001 << grant_num; available = 1'b0;
            end else if (r < 85) begin
                grant = 4'b0; available = 1'b1;
            end else begin
                grant = 4'($urandom); available = 1'($urandom);
            end
            release_req = ($urandom_range(0, 99) < 8) ? 4'($urandom) : 4'b0;
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            cyc(1);
        end
        set_quiet();
        cyc(2);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
